// File: rtl/async_req_arb_pkg.sv
// Shared types and constants for the asynchronous request arbiter.
// Channel state, default sizing and the post-reset grant hold-off.
package async_req_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACKD = 1'b1
  } chan_state_e;

  localparam int DEF_N       = 4;
  localparam int DEF_W       = 8;
  localparam int STARTUP_CNT = 2;

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchronizer for a W-bit bundle of independent asynchronous bits.
// Deliberately unreset so the metastability chain is never disturbed by reset.
module sync_ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk) begin
    r_meta <= i_d;
    r_sync <= r_meta;
  end

  assign o_q = r_sync;

endmodule

// File: rtl/async_req_arb.sv
// Round-robin arbiter for N 4-phase asynchronous requesters with bundled data,
// delivering one captured word at a time through a valid/ready output slot.
module async_req_arb
  import async_req_arb_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int W  = DEF_W,
  localparam int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_async,
  input  logic [N-1:0][W-1:0] data_async,
  output logic [N-1:0]        ack,
  output logic                out_vld,
  output logic [W-1:0]        out_data,
  output logic [IW-1:0]       out_idx,
  input  logic                out_rdy
);

  logic [N-1:0]  w_reqS;
  logic [N-1:0]  w_pending;
  logic [N-1:0]  w_ackNext;
  logic [N-1:0]  r_ack;
  chan_state_e   r_state     [N];
  chan_state_e   w_stateNext [N];
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_grantIdx;
  logic          w_grantVld;
  logic          w_slotFree;
  logic          w_startDone;
  logic [1:0]    r_startCnt;
  logic          r_outVld;
  logic [W-1:0]  r_outData;
  logic [IW-1:0] r_outIdx;

  sync_ff #(.W(N)) u_sync (
    .clk (clk),
    .i_d (req_async),
    .o_q (w_reqS)
  );

  assign w_slotFree  = !r_outVld || out_rdy;
  assign w_startDone = (r_startCnt == 2'(STARTUP_CNT));

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_pending[i] = (r_state[i] == IDLE) && w_reqS[i];
    end
  end

  // First pending channel at or after ptr, wrapping from N-1 back to 0.
  always_comb begin
    w_grantVld = 1'b0;
    w_grantIdx = '0;
    if (w_startDone && w_slotFree) begin
      for (int k = 0; k < N; k++) begin
        if (!w_grantVld && w_pending[(int'(r_ptr) + k) % N]) begin
          w_grantVld = 1'b1;
          w_grantIdx = IW'((int'(r_ptr) + k) % N);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_stateNext[i] = r_state[i];
      w_ackNext[i]   = r_ack[i];
      if (r_state[i] == ACKD && !w_reqS[i]) begin
        w_stateNext[i] = IDLE;
        w_ackNext[i]   = 1'b0;
      end
    end
    if (w_grantVld) begin
      w_stateNext[w_grantIdx] = ACKD;
      w_ackNext[w_grantIdx]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= IDLE;
      end
      r_ack <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= w_stateNext[i];
      end
      r_ack <= w_ackNext;
    end
  end

  // The startup counter covers the unreset synchronizer flushing after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_startCnt <= '0;
      r_outVld   <= 1'b0;
      r_outData  <= '0;
      r_outIdx   <= '0;
      r_ptr      <= '0;
    end else begin
      if (!w_startDone) begin
        r_startCnt <= r_startCnt + 2'd1;
      end
      if (w_grantVld) begin
        r_outVld  <= 1'b1;
        r_outData <= data_async[w_grantIdx];
        r_outIdx  <= w_grantIdx;
        r_ptr     <= (w_grantIdx == IW'(N - 1)) ? '0 : w_grantIdx + IW'(1);
      end else if (r_outVld && out_rdy) begin
        r_outVld <= 1'b0;
      end
    end
  end

  assign ack      = r_ack;
  assign out_vld  = r_outVld;
  assign out_data = r_outData;
  assign out_idx  = r_outIdx;

endmodule

// File: tb/tb_async_req_arb.sv
// Bench for async_req_arb: directed handshake scenarios plus randomized 4-phase
// requesters, all compared every cycle against a behavioural arbiter model.
module tb_async_req_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        reqAsync;
  logic [N-1:0][W-1:0] dataAsync;
  logic [N-1:0]        ack;
  logic                outVld;
  logic [W-1:0]        outData;
  logic [1:0]          outIdx;
  logic                outRdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  async_req_arb #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_async  (reqAsync),
    .data_async (dataAsync),
    .ack        (ack),
    .out_vld    (outVld),
    .out_data   (outData),
    .out_idx    (outIdx),
    .out_rdy    (outRdy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: synchronizer as a two-sample delay line, busy flags per channel.
  bit           mBusy [N];
  int           waits [N];
  int           mPtr = 0, mCnt = 0, mIdx = 0, maxWait = 0, grantTotal = 0;
  bit           mVld = 0;
  logic [W-1:0] mData = '0;
  logic [N-1:0] mS1 = '0, mS2 = '0;

  always @(posedge clk) begin : model
    logic [N-1:0] rs;
    bit           pend [N];
    bit           free;
    int           gnt;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mBusy[i] = 0;
        waits[i] = 0;
      end
      mPtr = 0; mCnt = 0; mVld = 0; mData = '0; mIdx = 0;
    end else begin
      rs   = mS2;
      free = !mVld || outRdy;
      gnt  = -1;
      for (int i = 0; i < N; i++) pend[i] = !mBusy[i] && rs[i];
      if (mCnt >= 2 && free) begin
        for (int k = 0; k < N; k++) begin
          if (gnt < 0 && pend[(mPtr + k) % N]) gnt = (mPtr + k) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (mBusy[i] && !rs[i]) mBusy[i] = 0;
        if (!pend[i]) waits[i] = 0;
      end
      if (gnt >= 0) begin
        for (int i = 0; i < N; i++) begin
          if (i != gnt && pend[i]) begin
            waits[i]++;
            if (waits[i] > maxWait) maxWait = waits[i];
          end
        end
        waits[gnt]  = 0;
        mBusy[gnt]  = 1;
        mVld        = 1;
        mData       = dataAsync[gnt];
        mIdx        = gnt;
        mPtr        = (gnt + 1) % N;
        grantTotal++;
      end else if (mVld && outRdy) begin
        mVld = 0;
      end
      if (mCnt < 2) mCnt++;
    end
    mS2 = mS1;
    mS1 = reqAsync;
  end

  // Per-cycle comparison, away from the active edge; reset forces all-zero outputs.
  always @(negedge clk) begin : compare
    logic [N-1:0] expAck;
    for (int i = 0; i < N; i++) expAck[i] = rst_n ? mBusy[i] : 1'b0;
    checkOutput("cyc_ack",      32'(ack),     32'(expAck));
    checkOutput("cyc_out_vld",  32'(outVld),  rst_n ? 32'(mVld)  : 32'd0);
    checkOutput("cyc_out_data", 32'(outData), rst_n ? 32'(mData) : 32'd0);
    checkOutput("cyc_out_idx",  32'(outIdx),  rst_n ? 32'(mIdx)  : 32'd0);
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int agState [N];
  int agCnt   [N];

  // Randomized well-behaved 4-phase requesters and a randomly stalling consumer.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      case (agState[i])
        0: begin
          dataAsync[i] = W'($urandom);
          if (agCnt[i] == 0) begin
            reqAsync[i] = 1'b1;
            agState[i]  = 1;
          end else agCnt[i]--;
        end
        1: if (ack[i]) begin
          agState[i] = 2;
          agCnt[i]   = int'($urandom_range(0, 3));
        end
        2: if (agCnt[i] == 0) begin
          reqAsync[i] = 1'b0;
          agState[i]  = 3;
        end else agCnt[i]--;
        default: if (!ack[i]) begin
          agState[i] = 0;
          agCnt[i]   = int'($urandom_range(0, 5));
        end
      endcase
    end
    outRdy = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    rst_n     = 1'b1;
    reqAsync  = '0;
    dataAsync = '0;
    outRdy    = 1'b1;
    #1 rst_n  = 1'b0;
    waitEdges(3);
    checkOutput("reset_ack",      32'(ack),     32'd0);
    checkOutput("reset_out_vld",  32'(outVld),  32'd0);
    checkOutput("reset_out_data", 32'(outData), 32'd0);
    checkOutput("reset_out_idx",  32'(outIdx),  32'd0);
    rst_n = 1'b1;
    waitEdges(4);

    // Single request: grant after exactly three edges, release after three more.
    dataAsync[2] = 8'hA5;
    reqAsync[2]  = 1'b1;
    waitEdges(2);
    checkOutput("single_no_early_vld", 32'(outVld), 32'd0);
    waitEdges(1);
    checkOutput("single_vld",  32'(outVld),  32'd1);
    checkOutput("single_idx",  32'(outIdx),  32'd2);
    checkOutput("single_data", 32'(outData), 32'hA5);
    checkOutput("single_ack",  32'(ack),     32'b0100);
    reqAsync[2] = 1'b0;
    waitEdges(2);
    checkOutput("single_ack_still_high", 32'(ack), 32'b0100);
    waitEdges(1);
    checkOutput("single_ack_low", 32'(ack), 32'd0);
    waitEdges(2);

    // Contention from ptr=0 after a fresh reset.
    rst_n = 1'b0;
    waitEdges(2);
    rst_n = 1'b1;
    waitEdges(4);
    for (int i = 0; i < N; i++) dataAsync[i] = W'(8'h10 * i + 8'h0C);
    reqAsync = 4'b1111;
    waitEdges(2);
    for (int i = 0; i < N; i++) begin
      waitEdges(1);
      checkOutput($sformatf("contend_vld_%0d", i), 32'(outVld), 32'd1);
      checkOutput($sformatf("contend_idx_%0d", i), 32'(outIdx), 32'(i));
    end
    reqAsync = '0;
    waitEdges(4);
    checkOutput("contend_all_released", 32'(ack), 32'd0);
    reqAsync = 4'b0011;
    waitEdges(3);
    checkOutput("ptr_wrapped_to_0", 32'(outIdx), 32'd0);
    waitEdges(1);
    checkOutput("ptr_next_is_1", 32'(outIdx), 32'd1);
    reqAsync = '0;
    waitEdges(4);

    // Backpressure: channel 1 held in the slot while channel 3 waits.
    outRdy       = 1'b0;
    dataAsync[1] = 8'h11;
    dataAsync[3] = 8'h33;
    reqAsync[1]  = 1'b1;
    waitEdges(1);
    reqAsync[3]  = 1'b1;
    waitEdges(2);
    checkOutput("bp_first_idx", 32'(outIdx), 32'd1);
    waitEdges(5);
    checkOutput("bp_hold_vld",  32'(outVld),  32'd1);
    checkOutput("bp_hold_data", 32'(outData), 32'h11);
    checkOutput("bp_hold_idx",  32'(outIdx),  32'd1);
    checkOutput("bp_ack3_low",  32'(ack),     32'b0010);
    outRdy = 1'b1;
    waitEdges(1);
    checkOutput("bp_b2b_vld",  32'(outVld),  32'd1);
    checkOutput("bp_b2b_idx",  32'(outIdx),  32'd3);
    checkOutput("bp_b2b_data", 32'(outData), 32'h33);
    reqAsync = '0;
    waitEdges(4);

    // Early request held through reset release.
    rst_n        = 1'b0;
    dataAsync[0] = 8'h5C;
    reqAsync[0]  = 1'b1;
    waitEdges(3);
    rst_n = 1'b1;
    waitEdges(1);
    checkOutput("early_edge1_no_vld", 32'(outVld), 32'd0);
    waitEdges(1);
    checkOutput("early_edge2_no_vld", 32'(outVld), 32'd0);
    waitEdges(1);
    checkOutput("early_grant_vld",  32'(outVld),  32'd1);
    checkOutput("early_grant_data", 32'(outData), 32'h5C);
    reqAsync = '0;
    waitEdges(4);

    // Reset asserted between edges while ack[1] is high.
    outRdy       = 1'b0;
    dataAsync[1] = 8'h66;
    reqAsync[1]  = 1'b1;
    waitEdges(3);
    checkOutput("midrst_ack_before", 32'(ack), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack_async", 32'(ack),    32'd0);
    checkOutput("midrst_vld_async", 32'(outVld), 32'd0);
    waitEdges(2);
    reqAsync = '0;
    outRdy   = 1'b1;
    waitEdges(1);
    rst_n = 1'b1;
    waitEdges(4);

    // Quick re-request: second grant only once ack[0] has dropped.
    dataAsync[0] = 8'h77;
    reqAsync[0]  = 1'b1;
    waitEdges(3);
    checkOutput("rereq_first_ack", 32'(ack[0]), 32'd1);
    reqAsync[0]  = 1'b0;
    waitEdges(1);
    dataAsync[0] = 8'h78;
    reqAsync[0]  = 1'b1;
    waitEdges(1);
    checkOutput("rereq_ack_held", 32'(ack[0]), 32'd1);
    waitEdges(1);
    checkOutput("rereq_ack_dropped", 32'(ack[0]), 32'd0);
    checkOutput("rereq_no_vld",      32'(outVld), 32'd0);
    waitEdges(1);
    checkOutput("rereq_second_vld",  32'(outVld),  32'd1);
    checkOutput("rereq_second_data", 32'(outData), 32'h78);
    checkOutput("rereq_second_ack",  32'(ack[0]),  32'd1);
    reqAsync = '0;
    waitEdges(4);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < N; i++) begin
      agState[i] = 0;
      agCnt[i]   = int'($urandom_range(0, 3));
    end
    for (int c = 0; c < 3000; c++) begin
      waitEdges(1);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      applyStimulus();
    end
    outRdy   = 1'b1;
    reqAsync = '0;
    waitEdges(6);

    checkOutput("fairness_max_wait", 32'(maxWait <= N - 1), 32'd1);
    checkOutput("traffic_exercised", 32'(grantTotal > 200), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
